// File: rtl/bit_reverse_loader_pkg.sv
// Shared definitions for the FFT input reorder path: bank-state encoding,
// index bit reversal and a ceil-log2 helper (also used by the dereverser).
package bit_reverse_loader_pkg;

    localparam int unsigned MAX_C_W = 16;

    // Per-bank occupancy state
    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FILLING  = 2'd1;
    localparam logic [1:0] BANK_FULL     = 2'd2;
    localparam logic [1:0] BANK_DRAINING = 2'd3;

    // Ceil-log2 usable in parameter context
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low w bits of v; bits above w come back as zero
    function automatic logic [MAX_C_W-1:0] bitrev(input logic [MAX_C_W-1:0] v,
                                                  input int unsigned w);
        logic [MAX_C_W-1:0] src;
        logic [MAX_C_W-1:0] r;
        src = v;
        r   = '0;
        for (int unsigned i = 0; i < MAX_C_W; i++) begin
            if (i < w) begin
                r   = {r[MAX_C_W-2:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_loader_reorder_skid2.sv
// Two-entry valid/ready skid FIFO. The head entry drives the outputs directly
// from flops; the spare entry absorbs the read that was in flight when the
// consumer stalled. The producer guarantees it never pushes into a full skid.
module reorder_skid2 #(
    parameter int unsigned W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_data,
    output logic [1:0]   count_c
);

    logic         spare_vld;
    logic [W-1:0] spare_data;
    logic         pop_eff;

    assign pop_eff = pop & head_vld;
    assign count_c = 2'(head_vld) + 2'(spare_vld);

    // Head/spare update for every push/pop combination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld   <= 1'b0;
            head_data  <= '0;
            spare_vld  <= 1'b0;
            spare_data <= '0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (!head_vld) begin
                        head_data <= push_data;
                        head_vld  <= 1'b1;
                    end else begin
                        spare_data <= push_data;
                        spare_vld  <= 1'b1;
                    end
                end
                2'b01: begin
                    if (spare_vld) begin
                        head_data <= spare_data;
                        spare_vld <= 1'b0;
                    end else begin
                        head_vld <= 1'b0;
                    end
                end
                2'b11: begin
                    if (spare_vld) begin
                        head_data  <= spare_data;
                        spare_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bit_reverse_loader.sv
// Natural-order to bit-reversed-order sample loader for the FFT input.
// Ping-pong bank pair: one bank fills from the source while the other drains
// in bit-reversed address order into a 2-entry output skid.
// Optional feature macro: BITREV_FRAME_CHECK_EN (frame alignment check/resync
// on i_new_fft, reported on o_frame_err).
module bit_reverse_loader
    import bit_reverse_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              mclk,
    input  logic              i_init_n,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic              i_new_fft,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_new_fft,
    output logic [DATA_W-1:0] o_data,
    output logic              o_frame_err
);

    localparam int unsigned C_W    = clog2(DEPTH);
    localparam int unsigned SKID_W = DATA_W + 1;

    // Control state
    logic [1:0][1:0] st_q, st_n;
    logic            wr_bank_q, wr_bank_n;
    logic            rd_bank_q, rd_bank_n;
    logic [C_W-1:0]  wptr_q, wptr_n;
    logic [C_W-1:0]  rptr_q, rptr_n;
    logic            rdy_n;
    logic            err_n;
    logic            resync_c;

    // Read pipeline
    logic            rd_pend_q;
    logic            rd_tag_q;
    logic            rd_sel_q;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;

    // Storage
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic            wr_en_c;
    logic            rd_en_c;
    logic            rd_avail_c;
    logic            credit_ok_c;
    logic            pop_c;
    logic [2:0]      used_c;
    logic [1:0]      skid_cnt_c;
    logic [C_W-1:0]  wr_addr_c;
    logic [C_W-1:0]  rd_addr_c;
    logic [SKID_W-1:0] skid_head;

`ifndef BITREV_FRAME_CHECK_EN
    logic unused_new_fft;
    assign unused_new_fft = i_new_fft;
`endif

    assign wr_en_c     = i_vld & o_rdy;
    assign pop_c       = o_vld & i_rdy;
    assign rd_avail_c  = (st_q[rd_bank_q] == BANK_FULL) || (st_q[rd_bank_q] == BANK_DRAINING);
    assign used_c      = 3'(rd_pend_q) + 3'(skid_cnt_c) - 3'(pop_c);
    assign credit_ok_c = used_c < 3'd2;
    assign rd_en_c     = rd_avail_c & credit_ok_c;
    assign rd_addr_c   = C_W'(bitrev(MAX_C_W'(rptr_q), C_W));

    // Next-state: bank states, pointers, ready and frame-error pulse
    always_comb begin
        st_n      = st_q;
        wr_bank_n = wr_bank_q;
        rd_bank_n = rd_bank_q;
        wptr_n    = wptr_q;
        rptr_n    = rptr_q;
        err_n     = 1'b0;
        resync_c  = 1'b0;
        wr_addr_c = wptr_q;

        if (wr_en_c) begin
`ifdef BITREV_FRAME_CHECK_EN
            if (i_new_fft && (wptr_q != '0)) begin
                // Misaligned frame start: drop the partial frame, restart at index 0
                err_n     = 1'b1;
                resync_c  = 1'b1;
                wr_addr_c = '0;
                wptr_n    = C_W'(1);
                st_n[wr_bank_q] = BANK_FILLING;
            end else if (!i_new_fft && (wptr_q == '0)) begin
                err_n = 1'b1;
            end
`endif
            if (!resync_c) begin
                if (wptr_q == C_W'(DEPTH - 1)) begin
                    st_n[wr_bank_q] = BANK_FULL;
                    wr_bank_n       = ~wr_bank_q;
                    wptr_n          = '0;
                end else begin
                    st_n[wr_bank_q] = BANK_FILLING;
                    wptr_n          = wptr_q + C_W'(1);
                end
            end
        end

        if (rd_en_c) begin
            if (rptr_q == C_W'(DEPTH - 1)) begin
                st_n[rd_bank_q] = BANK_EMPTY;
                rd_bank_n       = ~rd_bank_q;
                rptr_n          = '0;
            end else begin
                st_n[rd_bank_q] = BANK_DRAINING;
                rptr_n          = rptr_q + C_W'(1);
            end
        end

        rdy_n = (st_n[wr_bank_n] != BANK_FULL) && (st_n[wr_bank_n] != BANK_DRAINING);
    end

    // State register
    always_ff @(posedge mclk or negedge i_init_n) begin
        if (!i_init_n) begin
            st_q        <= {BANK_EMPTY, BANK_EMPTY};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            o_rdy       <= 1'b0;
            o_frame_err <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            st_q        <= st_n;
            wr_bank_q   <= wr_bank_n;
            rd_bank_q   <= rd_bank_n;
            wptr_q      <= wptr_n;
            rptr_q      <= rptr_n;
            o_rdy       <= rdy_n;
            o_frame_err <= err_n;
            rd_pend_q   <= rd_en_c;
            rd_tag_q    <= (rptr_q == '0);
            rd_sel_q    <= rd_bank_q;
        end
    end

    // Bank A: simple dual-port RAM, registered read
    always_ff @(posedge mclk) begin
        if (wr_en_c && !wr_bank_q) mem_a[wr_addr_c] <= i_data;
        if (rd_en_c && !rd_bank_q) rd_a_q <= mem_a[rd_addr_c];
    end

    // Bank B: simple dual-port RAM, registered read
    always_ff @(posedge mclk) begin
        if (wr_en_c && wr_bank_q) mem_b[wr_addr_c] <= i_data;
        if (rd_en_c && rd_bank_q) rd_b_q <= mem_b[rd_addr_c];
    end

    reorder_skid2 #(
        .W (SKID_W)
    ) u_skid (
        .clk       (mclk),
        .rst_n     (i_init_n),
        .push      (rd_pend_q),
        .push_data ({rd_tag_q, (rd_sel_q ? rd_b_q : rd_a_q)}),
        .pop       (i_rdy),
        .head_vld  (o_vld),
        .head_data (skid_head),
        .count_c   (skid_cnt_c)
    );

    assign o_new_fft = skid_head[DATA_W];
    assign o_data    = skid_head[DATA_W-1:0];

endmodule

// File: tb/tb_bit_reverse_loader.sv
// Self-checking bench for bit_reverse_loader (DEPTH=8). Honors
// BITREV_FRAME_CHECK_EN to pick the expected frame-alignment behaviour.
module tb_bit_reverse_loader;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned LOG_N  = 3;

    logic              mclk = 1'b0;
    logic              i_init_n;
    logic              i_vld;
    logic              o_rdy;
    logic              i_new_fft;
    logic [DATA_W-1:0] i_data;
    logic              o_vld;
    logic              i_rdy;
    logic              o_new_fft;
    logic [DATA_W-1:0] o_data;
    logic              o_frame_err;

    always #5 mclk = ~mclk;

    bit_reverse_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .mclk        (mclk),
        .i_init_n    (i_init_n),
        .i_vld       (i_vld),
        .o_rdy       (o_rdy),
        .i_new_fft   (i_new_fft),
        .i_data      (i_data),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_new_fft   (o_new_fft),
        .o_data      (o_data),
        .o_frame_err (o_frame_err)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              nf;
    } smp_t;

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] exp_dout;
        logic              exp_nf;
    } vec_t;

    vec_t              tbl [16];
    smp_t              exp_q [$];
    smp_t              got [$];
    logic [DATA_W-1:0] cur [$];

    int   checks = 0;
    int   errors = 0;
    logic err_q = 1'b0;
    logic prev_stall = 1'b0;
    smp_t prev;
    int   err_seen = 0;
    int   sent = 0;
    logic rnd_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reverse the LOG_N-digit binary representation of j
    function automatic int rev_idx(input int j);
        int r;
        int x;
        r = 0;
        x = j;
        for (int b = 0; b < LOG_N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Reference: collect frames of DEPTH beats, emit them in reversed-index order
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic nf);
        smp_t e;
`ifdef BITREV_FRAME_CHECK_EN
        if (nf && cur.size() != 0) begin
            err_q = 1'b1;
            cur.delete();
        end else if (!nf && cur.size() == 0) begin
            err_q = 1'b1;
        end
`else
        if (nf) err_q = 1'b0;
`endif
        cur.push_back(d);
        if (cur.size() == DEPTH) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                e.data = cur[rev_idx(j)];
                e.nf   = (j == 0);
                exp_q.push_back(e);
            end
            cur.delete();
        end
    endtask

    task automatic monitor();
        smp_t e;
        smp_t o;
        if (!i_init_n) begin
            exp_q.delete();
            cur.delete();
            err_q      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("frame_err", 32'(o_frame_err), 32'(err_q));
            if (o_frame_err) err_seen++;
            err_q = 1'b0;
            if (prev_stall) begin
                check("stall_vld", 32'(o_vld), 32'd1);
                check("stall_data", 32'(o_data), 32'(prev.data));
                check("stall_nf", 32'(o_new_fft), 32'(prev.nf));
            end
            if (o_vld && i_rdy) begin
                o.data = o_data;
                o.nf   = o_new_fft;
                got.push_back(o);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got data %0h, expected no output", o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(o_data), 32'(e.data));
                    check("out_new_fft", 32'(o_new_fft), 32'(e.nf));
                end
            end
            prev_stall = o_vld && !i_rdy;
            prev.data  = o_data;
            prev.nf    = o_new_fft;
            if (i_vld && o_rdy) model_accept(i_data, i_new_fft);
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge mclk);
        monitor();
        @(posedge mclk);
        #1;
        if (rnd_mode) i_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic nf);
        logic acc;
        i_vld     = 1'b1;
        i_data    = d;
        i_new_fft = nf;
        acc       = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = o_rdy;
            tick();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got o_rdy 0 for 300 cycles, expected 1");
        end
        i_vld = 1'b0;
        sent++;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) tick();
        check("drain_done", 32'(exp_q.size()), 32'd0);
        for (int t = 0; t < 4; t++) tick();
    endtask

    initial begin
        int exp_list [16] = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
        int first_vld;
        int gaps;
        int rdy_drop;
        int acc_cnt;

        i_init_n  = 1'b0;
        i_vld     = 1'b0;
        i_new_fft = 1'b0;
        i_data    = '0;
        i_rdy     = 1'b1;

        for (int k = 0; k < 16; k++) begin
            tbl[k].din      = DATA_W'(k);
            tbl[k].exp_dout = DATA_W'(exp_list[k]);
            tbl[k].exp_nf   = (k == 0) || (k == 8);
        end

        // Reset state
        #12;
        check("rst_o_vld", 32'(o_vld), 32'd0);
        check("rst_o_rdy", 32'(o_rdy), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_new_fft", 32'(o_new_fft), 32'd0);
        check("rst_o_frame_err", 32'(o_frame_err), 32'd0);
        @(posedge mclk);
        #1;
        i_init_n = 1'b1;

        // Two ramp frames against the literal reordered table
        got.delete();
        for (int k = 0; k < 16; k++) send(tbl[k].din, (k % 8) == 0);
        drain(100);
        check("tbl_count", 32'(got.size()), 32'd16);
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            check("tbl_data", 32'(got[k].data), 32'(tbl[k].exp_dout));
            check("tbl_nf", 32'(got[k].nf), 32'(tbl[k].exp_nf));
        end

        // Four back-to-back frames: latency, gapless output, no input stall
        for (int t = 0; t < 20 && !o_rdy; t++) tick();
        first_vld = -1;
        gaps      = 0;
        rdy_drop  = 0;
        for (int c = 0; c < 45; c++) begin
            if (c > 0 && o_vld && first_vld < 0) first_vld = c;
            if (c >= 10 && c <= 41 && !o_vld) gaps++;
            if (c < 32 && !o_rdy) rdy_drop++;
            if (c == 42) check("stream_tail_idle", 32'(o_vld), 32'd0);
            i_vld     = (c < 32);
            i_data    = DATA_W'(100 + c);
            i_new_fft = (c % 8) == 0;
            tick();
        end
        i_vld = 1'b0;
        sent  = sent + 32;
        check("stream_first_vld_cycle", 32'(first_vld), 32'd10);
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_rdy_drops", 32'(rdy_drop), 32'd0);
        drain(50);

        // Random source gaps and random downstream backpressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int t = 0; t < idle; t++) tick();
            send(DATA_W'($urandom), (sent % 8) == 0);
        end
        drain(600);
        rnd_mode = 1'b0;

        // Full stall: exactly two frames fit before o_rdy drops
        i_rdy   = 1'b0;
        i_vld   = 1'b1;
        acc_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            i_data    = DATA_W'($urandom);
            i_new_fft = (sent % 8) == 0;
            if (o_rdy) begin
                acc_cnt++;
                sent++;
            end
            tick();
        end
        check("stall_accepted", 32'(acc_cnt), 32'd16);
        check("stall_o_rdy", 32'(o_rdy), 32'd0);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        drain(200);

        // Async reset in the middle of the second frame's drain
        got.delete();
        for (int k = 0; k < 16; k++) send(DATA_W'($urandom), (k % 8) == 0);
        for (int t = 0; t < 100 && got.size() < 11; t++) tick();
        i_init_n = 1'b0;
        #1;
        check("midrst_o_vld", 32'(o_vld), 32'd0);
        check("midrst_o_rdy", 32'(o_rdy), 32'd0);
        check("midrst_o_data", 32'(o_data), 32'd0);
        check("midrst_o_new_fft", 32'(o_new_fft), 32'd0);
        tick();
        tick();
        i_init_n = 1'b1;
        sent     = 0;
        got.delete();
        for (int k = 0; k < 8; k++) send(DATA_W'($urandom), k == 0);
        drain(100);
        for (int t = 0; t < 16; t++) tick();
        check("postrst_count", 32'(got.size()), 32'd8);

        // Frame marker arriving at beat 3
        got.delete();
        err_seen = 0;
        for (int k = 0; k < 11; k++) send(DATA_W'($urandom), (k == 0) || (k == 3));
        drain(100);
`ifdef BITREV_FRAME_CHECK_EN
        check("misalign_err_pulses", 32'(err_seen), 32'd1);
`else
        check("misalign_err_pulses", 32'(err_seen), 32'd0);
`endif
        check("misalign_count", 32'(got.size()), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
